// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types: stall FSM state encoding and the per-stage
// write-enable/flush bundle driven into the PC, IF/ID, ID/EX and EX/MEM registers.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  // Width of the redirect hold counter; REDIRECT_CYCLES is limited to 0..7
  localparam int unsigned REDIR_CNT_W = 3;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_DEFAULT = '{
    pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
    id_ex_we: 1'b1, id_ex_flush: 1'b0, ex_mem_flush: 1'b0
  };

  localparam stage_ctrl_t CTRL_RESET = '{
    pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
    id_ex_we: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b1
  };

  // Load-use: hold PC and IF/ID, inject a bubble into ID/EX
  localparam stage_ctrl_t CTRL_HAZARD = '{
    pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
    id_ex_we: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b0
  };

  // Multi-cycle M-unit: freeze front end and EX, bubble into EX/MEM
  localparam stage_ctrl_t CTRL_MD_FREEZE = '{
    pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
    id_ex_we: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b1
  };

  // Taken branch: PC loads target, squash the two wrong-path instructions
  localparam stage_ctrl_t CTRL_REDIRECT = '{
    pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
    id_ex_we: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b0
  };

  function automatic stage_ctrl_t hazard_or_default(input logic hazard);
    return hazard ? CTRL_HAZARD : CTRL_DEFAULT;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Converts load-use stalls, branch redirects and MUL/DIV handshakes into
// zero-latency per-stage write-enable/flush controls, plus perf counters.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_CYCLES = 1,
  parameter int unsigned MD_TIMEOUT      = 64,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_done,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_write_en,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             md_timeout
);

  localparam int unsigned TO_W = $clog2(MD_TIMEOUT + 1);
  localparam int unsigned RW   = REDIR_CNT_W;

  state_t          state, state_next;
  logic [TO_W-1:0] to_cnt, to_cnt_next;
  logic [RW-1:0]   redir_cnt, redir_cnt_next;
  logic            timeout_hit;
  logic            branch_accept;
  stage_ctrl_t     ctrl;
  logic            cnt_clr;
  logic            stall_en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RUN;
      to_cnt     <= '0;
      redir_cnt  <= '0;
      md_timeout <= 1'b0;
    end else begin
      state     <= state_next;
      to_cnt    <= to_cnt_next;
      redir_cnt <= redir_cnt_next;
      if (timeout_hit) begin
        md_timeout <= 1'b1;
      end
    end
  end

  // Next-state and combinational stage controls
  always_comb begin
    state_next     = state;
    to_cnt_next    = to_cnt;
    redir_cnt_next = redir_cnt;
    timeout_hit    = 1'b0;
    branch_accept  = 1'b0;
    ctrl           = CTRL_DEFAULT;

    case (state)
      RUN: begin
        if (branch_taken) begin
          // Wrong-path hazard/md_start in the same cycle are dropped
          ctrl          = CTRL_REDIRECT;
          branch_accept = 1'b1;
          if (REDIRECT_CYCLES != 0) begin
            state_next     = REDIRECT;
            redir_cnt_next = RW'(REDIRECT_CYCLES);
          end
        end else if (md_start && !md_done) begin
          ctrl        = CTRL_MD_FREEZE;
          state_next  = MD_WAIT;
          to_cnt_next = TO_W'(1);
        end else begin
          ctrl = hazard_or_default(hazard_stall);
        end
      end

      MD_WAIT: begin
        if (md_done) begin
          ctrl       = hazard_or_default(hazard_stall);
          state_next = RUN;
        end else if (to_cnt == TO_W'(MD_TIMEOUT)) begin
          // Forced release so a hung M-unit cannot wedge the pipeline
          ctrl        = hazard_or_default(hazard_stall);
          state_next  = RUN;
          timeout_hit = 1'b1;
        end else begin
          ctrl        = CTRL_MD_FREEZE;
          to_cnt_next = to_cnt + TO_W'(1);
        end
      end

      REDIRECT: begin
        ctrl = CTRL_REDIRECT;
        if (redir_cnt <= RW'(1)) begin
          state_next = RUN;
        end else begin
          redir_cnt_next = redir_cnt - RW'(1);
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase

    if (!reset_n) begin
      ctrl          = CTRL_RESET;
      branch_accept = 1'b0;
      timeout_hit   = 1'b0;
    end
  end

  assign pc_write_en    = ctrl.pc_we;
  assign if_id_write_en = ctrl.if_id_we;
  assign if_id_flush    = ctrl.if_id_flush;
  assign id_ex_write_en = ctrl.id_ex_we;
  assign id_ex_flush    = ctrl.id_ex_flush;
  assign ex_mem_flush   = ctrl.ex_mem_flush;

  assign cnt_clr  = ~reset_n;
  assign stall_en = reset_n & ~ctrl.pc_we;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .en  (stall_en),
    .clr (cnt_clr),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .en  (branch_accept),
    .clr (cnt_clr),
    .q   (flush_events)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with small counters so saturation is reachable.
module tb_pipeline_stall_ctrl;

  localparam int unsigned CW = 4;

  // Expected control bundles {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush}
  localparam logic [5:0] E_DEF   = 6'b110100;
  localparam logic [5:0] E_RST   = 6'b001011;
  localparam logic [5:0] E_HAZ   = 6'b000110;
  localparam logic [5:0] E_FRZ   = 6'b000001;
  localparam logic [5:0] E_REDIR = 6'b111110;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hazard_stall, branch_taken, md_start, md_done;
  logic          pc_write_en, if_id_write_en, if_id_flush;
  logic          id_ex_write_en, id_ex_flush, ex_mem_flush;
  logic [CW-1:0] stall_cycles, flush_events;
  logic          md_timeout;
  logic [5:0]    ctrl_obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .REDIRECT_CYCLES(1),
    .MD_TIMEOUT     (8),
    .CNT_W          (CW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hazard_stall  (hazard_stall),
    .branch_taken  (branch_taken),
    .md_start      (md_start),
    .md_done       (md_done),
    .pc_write_en   (pc_write_en),
    .if_id_write_en(if_id_write_en),
    .if_id_flush   (if_id_flush),
    .id_ex_write_en(id_ex_write_en),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_flush  (ex_mem_flush),
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events),
    .md_timeout    (md_timeout)
  );

  assign ctrl_obs = {pc_write_en, if_id_write_en, if_id_flush,
                     id_ex_write_en, id_ex_flush, ex_mem_flush};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; hazard_stall = 1'b0; branch_taken = 1'b0;
    md_start = 1'b0; md_done = 1'b0;

    // Reset: forced flush controls
    settle(); chk("rst_ctrl0", 8'(ctrl_obs), 8'(E_RST));
    next_cycle(); settle(); chk("rst_ctrl1", 8'(ctrl_obs), 8'(E_RST));
    next_cycle(); reset_n = 1'b1;
    settle();
    chk("post_rst_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    chk("post_rst_stall", 8'(stall_cycles), 8'd0);
    chk("post_rst_flush", 8'(flush_events), 8'd0);
    chk("post_rst_to", 8'(md_timeout), 8'd0);

    // Single-cycle load-use stall
    next_cycle(); hazard_stall = 1'b1;
    settle(); chk("haz_ctrl", 8'(ctrl_obs), 8'(E_HAZ));
    next_cycle(); hazard_stall = 1'b0;
    settle(); chk("haz_after_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    chk("haz_stall_cnt", 8'(stall_cycles), 8'd1);

    // MUL/DIV: start, 3 wait cycles, done on 4th cycle after start
    next_cycle(); md_start = 1'b1;
    settle(); chk("md_start_ctrl", 8'(ctrl_obs), 8'(E_FRZ));
    for (int i = 0; i < 3; i++) begin
      next_cycle(); md_start = 1'b0;
      settle(); chk($sformatf("md_wait%0d_ctrl", i), 8'(ctrl_obs), 8'(E_FRZ));
    end
    next_cycle(); md_done = 1'b1;
    settle(); chk("md_done_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    next_cycle(); md_done = 1'b0;
    settle(); chk("md_after_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    chk("md_stall_cnt", 8'(stall_cycles), 8'd5);

    // Single-cycle M op: no freeze
    next_cycle(); md_start = 1'b1; md_done = 1'b1;
    settle(); chk("md1_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    next_cycle(); md_start = 1'b0; md_done = 1'b0;
    settle(); chk("md1_after_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    chk("md1_stall_cnt", 8'(stall_cycles), 8'd5);

    // Single-cycle M op with a load-use stall still honoured
    next_cycle(); md_start = 1'b1; md_done = 1'b1; hazard_stall = 1'b1;
    settle(); chk("md1_haz_ctrl", 8'(ctrl_obs), 8'(E_HAZ));
    next_cycle(); md_start = 1'b0; md_done = 1'b0; hazard_stall = 1'b0;
    settle(); chk("md1_haz_stall_cnt", 8'(stall_cycles), 8'd6);

    // Branch with simultaneous hazard: redirect wins, flush held one extra cycle
    next_cycle(); branch_taken = 1'b1; hazard_stall = 1'b1;
    settle(); chk("br_ctrl", 8'(ctrl_obs), 8'(E_REDIR));
    next_cycle(); branch_taken = 1'b0;
    settle(); chk("br_redir_ctrl", 8'(ctrl_obs), 8'(E_REDIR));
    next_cycle(); hazard_stall = 1'b0;
    settle(); chk("br_after_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    chk("br_flush_cnt", 8'(flush_events), 8'd1);
    chk("br_stall_cnt", 8'(stall_cycles), 8'd6);

    // MD release coinciding with a load-use stall
    next_cycle(); md_start = 1'b1;
    settle(); chk("mdh_start_ctrl", 8'(ctrl_obs), 8'(E_FRZ));
    next_cycle(); md_start = 1'b0; md_done = 1'b1; hazard_stall = 1'b1;
    settle(); chk("mdh_rel_ctrl", 8'(ctrl_obs), 8'(E_HAZ));
    next_cycle(); md_done = 1'b0; hazard_stall = 1'b0;
    settle(); chk("mdh_after_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    chk("mdh_stall_cnt", 8'(stall_cycles), 8'd8);

    // M-unit timeout: released on 8th wait cycle, sticky flag, counter saturates
    next_cycle(); md_start = 1'b1;
    settle(); chk("to_start_ctrl", 8'(ctrl_obs), 8'(E_FRZ));
    for (int i = 1; i < 8; i++) begin
      next_cycle(); md_start = 1'b0;
      settle(); chk($sformatf("to_wait%0d_ctrl", i), 8'(ctrl_obs), 8'(E_FRZ));
    end
    chk("to_flag_early", 8'(md_timeout), 8'd0);
    next_cycle();
    settle(); chk("to_release_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    chk("to_flag_release_cycle", 8'(md_timeout), 8'd0);
    next_cycle();
    settle(); chk("to_after_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    chk("to_flag_set", 8'(md_timeout), 8'd1);
    chk("to_stall_sat", 8'(stall_cycles), 8'd15);
    next_cycle(); hazard_stall = 1'b1;
    settle(); chk("sat_haz_ctrl", 8'(ctrl_obs), 8'(E_HAZ));
    next_cycle(); hazard_stall = 1'b0;
    settle(); chk("sat_hold", 8'(stall_cycles), 8'd15);
    chk("to_flag_sticky", 8'(md_timeout), 8'd1);

    // Reset in the middle of MD_WAIT abandons the wait
    next_cycle(); md_start = 1'b1;
    next_cycle(); md_start = 1'b0;
    settle(); chk("rst_md_wait_ctrl", 8'(ctrl_obs), 8'(E_FRZ));
    next_cycle(); reset_n = 1'b0;
    settle(); chk("rst_md_ctrl", 8'(ctrl_obs), 8'(E_RST));
    next_cycle(); reset_n = 1'b1;
    settle(); chk("rst_md_after_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    chk("rst_md_to_clr", 8'(md_timeout), 8'd0);
    chk("rst_md_stall_clr", 8'(stall_cycles), 8'd0);
    chk("rst_md_flush_clr", 8'(flush_events), 8'd0);

    // Reset during REDIRECT abandons the redirect
    next_cycle(); branch_taken = 1'b1;
    next_cycle(); branch_taken = 1'b0; reset_n = 1'b0;
    settle(); chk("rst_br_ctrl", 8'(ctrl_obs), 8'(E_RST));
    next_cycle(); reset_n = 1'b1;
    settle(); chk("rst_br_after_ctrl", 8'(ctrl_obs), 8'(E_DEF));
    chk("rst_br_flush_clr", 8'(flush_events), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
